// File: rtl/intc_prio.sv
// Prioritised N-channel interrupt controller: sync, edge/level pending, mask, req/ack/EOI FSM.
// Latency: irq_in sampled at edge k -> pending_q after k+2 -> int_req after k+3.
// Backpressure: one request/ISR at a time; later sources stay pending until EOI.
module intc_prio #(
    parameter int                N_IRQ      = 3,
    parameter logic [N_IRQ-1:0]  EDGE_MASK  = {N_IRQ{1'b1}},
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0004,
    parameter int                VEC_STRIDE = 4,
    parameter int                ID_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [N_IRQ-1:0]  cfg_wdata,
    output logic [N_IRQ-1:0]  mask_q,
    output logic [N_IRQ-1:0]  pending_q,
    output logic              int_req,
    input  logic              int_ack,
    output logic [ID_W-1:0]   int_id,
    output logic [ADDR_W-1:0] int_vec,
    input  logic              int_eoi,
    output logic              in_service
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_IRQ-1:0]   r_s1;
    logic [N_IRQ-1:0]   r_s2;
    logic [N_IRQ-1:0]   r_s3;
    logic [N_IRQ-1:0]   r_mask;
    logic [N_IRQ-1:0]   r_pend;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_vec;

    logic [N_IRQ-1:0]   w_elig;
    logic [N_IRQ-1:0]   w_id_oh;
    logic [N_IRQ-1:0]   w_set;
    logic [N_IRQ-1:0]   w_clr;
    logic [N_IRQ-1:0]   w_pend_nxt;
    logic [ID_W-1:0]    w_win;
    logic [ADDR_W-1:0]  w_vec;
    logic               w_load;
    logic               w_ack_clr;

    assign w_elig  = r_pend & r_mask;
    assign w_id_oh = N_IRQ'(1) << r_id;
    assign w_set   = r_s2 & ~r_s3;

    // Ack-time clear only matters for edge channels; level bits just follow the line.
    assign w_clr = ((cfg_we && cfg_sel) ? cfg_wdata : '0) | (w_ack_clr ? w_id_oh : '0);
    assign w_pend_nxt = (EDGE_MASK & (w_set | (r_pend & ~w_clr))) | (~EDGE_MASK & r_s2);

    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = ID_W'(i);
            end
        end
    end

    assign w_vec = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(w_win);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ack_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_REQ;
                    w_load      = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_ack_clr   = 1'b1;
                end else if (!(|(w_elig & w_id_oh))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_id    <= '0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s1    <= irq_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            if (cfg_we && !cfg_sel) begin
                r_mask <= cfg_wdata;
            end
            if (w_load) begin
                r_id  <= w_win;
                r_vec <= w_vec;
            end
        end
    end

    assign mask_q     = r_mask;
    assign pending_q  = r_pend;
    assign int_req    = (r_state == ST_REQ);
    assign in_service = (r_state == ST_SERVICE);
    assign int_id     = r_id;
    assign int_vec    = r_vec;

endmodule

// File: tb/tb_intc_prio.sv
// Bench for intc_prio: directed vector table, hand sequences for level mode and async reset,
// then randomized traffic on an all-edge and a mixed edge/level instance against a reference model.
module tb_intc_prio;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [2:0]  m_irq, m_wd, m_mask, m_pend;
    logic        m_we, m_sel, m_ack, m_eoi, m_req, m_svc;
    logic [1:0]  m_id;
    logic [15:0] m_vec;

    logic [2:0]  l_irq, l_wd, l_mask, l_pend;
    logic        l_we, l_sel, l_ack, l_eoi, l_req, l_svc;
    logic [1:0]  l_id;
    logic [15:0] l_vec;

    intc_prio u_dut (
        .clk(clk), .reset(rst_n), .irq_in(m_irq), .cfg_we(m_we), .cfg_sel(m_sel),
        .cfg_wdata(m_wd), .mask_q(m_mask), .pending_q(m_pend), .int_req(m_req),
        .int_ack(m_ack), .int_id(m_id), .int_vec(m_vec), .int_eoi(m_eoi),
        .in_service(m_svc)
    );

    intc_prio #(.EDGE_MASK(3'b110)) u_lvl (
        .clk(clk), .reset(rst_n), .irq_in(l_irq), .cfg_we(l_we), .cfg_sel(l_sel),
        .cfg_wdata(l_wd), .mask_q(l_mask), .pending_q(l_pend), .int_req(l_req),
        .int_ack(l_ack), .int_id(l_id), .int_vec(l_vec), .int_eoi(l_eoi),
        .in_service(l_svc)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  irq;
        logic        we;
        logic        sel;
        logic [2:0]  wd;
        logic        ack;
        logic        eoi;
        logic [2:0]  pend;
        logic        req;
        logic [1:0]  id;
        logic [15:0] vec;
        logic        svc;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(logic [2:0] irq, logic we, logic sel, logic [2:0] wd,
                                logic ack, logic eoi, logic [2:0] pend, logic req,
                                logic [1:0] id, logic [15:0] vec, logic svc);
        return '{irq, we, sel, wd, ack, eoi, pend, req, id, vec, svc};
    endfunction

    // Reference model: behaviour by rule, phase 0 = idle, 1 = requesting, 2 = servicing.
    typedef struct {
        logic [2:0]  hist1, hist2, hist3;
        logic [2:0]  pend, mask;
        int          phase;
        int          id;
        logic [15:0] vec;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, logic [2:0] em, logic [2:0] irq, logic we,
                                   logic sel, logic [2:0] wd, logic ack, logic eoi);
        mdl_t       n = m;
        logic [2:0] elig = m.pend & m.mask;
        logic [2:0] clr = (we && sel) ? wd : 3'b000;
        int         win = -1;
        if (m.phase == 1 && ack) clr[m.id] = 1'b1;
        n.hist1 = irq;
        n.hist2 = m.hist1;
        n.hist3 = m.hist2;
        for (int i = 0; i < 3; i++) begin
            if (em[i]) n.pend[i] = (m.hist2[i] && !m.hist3[i]) || (m.pend[i] && !clr[i]);
            else       n.pend[i] = m.hist2[i];
        end
        if (we && !sel) n.mask = wd;
        for (int i = 2; i >= 0; i--) if (elig[i]) win = i;
        case (m.phase)
            0: if (win >= 0) begin
                   n.phase = 1;
                   n.id    = win;
                   n.vec   = 16'(4 + 4 * win);
               end
            1: if (ack) n.phase = 2;
               else if (!elig[m.id]) n.phase = 0;
            default: if (eoi) n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] mexp(mdl_t m);
        return {38'd0, m.mask, m.pend, (m.phase == 1), 2'(m.id), m.vec, (m.phase == 2)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lstep(logic [2:0] irq, logic we, logic [2:0] wd, logic ack, logic eoi);
        l_irq = irq; l_we = we; l_sel = 1'b0; l_wd = wd; l_ack = ack; l_eoi = eoi;
        cyc();
    endtask

    mdl_t mm, lm;
    mdl_t zero_m;

    initial begin
        rst_n = 1'b0;
        {m_irq, m_we, m_sel, m_wd, m_ack, m_eoi} = '0;
        {l_irq, l_we, l_sel, l_wd, l_ack, l_eoi} = '0;
        zero_m = '{3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 0, 0, 16'h0};

        // irq cfg:we sel wd  ack eoi | pend req id vec svc
        rows.push_back(mk(3'b000, 1, 0, 3'b111, 0, 0, 3'b000, 0, 0, 16'h0000, 0));
        rows.push_back(mk(3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 16'h0000, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 16'h0000, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 0, 0, 16'h0000, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 1, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b000, 0, 1, 16'h0008, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 1, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b101, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b101, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b101, 1, 0, 16'h0004, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b100, 0, 0, 16'h0004, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 1, 3'b100, 0, 0, 16'h0004, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b100, 1, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b000, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 1, 3'b000, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 1, 0, 3'b010, 0, 0, 3'b010, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 1, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 1, 1, 3'b010, 0, 0, 3'b000, 1, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 1, 0, 3'b111, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 1, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 1, 1, 3'b010, 0, 0, 3'b010, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b010, 1, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b000, 0, 1, 16'h0008, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 1, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b100, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b100, 0, 1, 16'h0008, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b100, 1, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b000, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b001, 0, 0, 3'b000, 0, 0, 3'b000, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b001, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b001, 0, 2, 16'h000C, 1));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 1, 3'b001, 0, 2, 16'h000C, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 0, 0, 3'b001, 1, 0, 16'h0004, 0));
        rows.push_back(mk(3'b000, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 16'h0004, 1));

        repeat (2) @(negedge clk);
        chk("reset_main", {m_mask, m_pend, m_req, m_id, m_vec, m_svc}, 64'd0);
        chk("reset_lvl",  {l_mask, l_pend, l_req, l_id, l_vec, l_svc}, 64'd0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < rows.size(); i++) begin
            m_irq = rows[i].irq; m_we = rows[i].we; m_sel = rows[i].sel;
            m_wd  = rows[i].wd;  m_ack = rows[i].ack; m_eoi = rows[i].eoi;
            cyc();
            chk($sformatf("row%0d", i), {m_pend, m_req, m_id, m_vec, m_svc},
                {rows[i].pend, rows[i].req, rows[i].id, rows[i].vec, rows[i].svc});
        end
        {m_irq, m_we, m_sel, m_wd, m_ack, m_eoi} = '0;
        chk("svc_before_reset", {63'd0, m_svc}, 64'd1);

        // Asynchronous reset mid-service, well away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {m_mask, m_pend, m_req, m_id, m_vec, m_svc}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Level channel 0 on the mixed instance.
        lstep(3'b000, 1, 3'b111, 0, 0);
        lstep(3'b001, 0, 3'b000, 0, 0);
        lstep(3'b001, 0, 3'b000, 0, 0);
        lstep(3'b001, 0, 3'b000, 0, 0);
        chk("lvl_pend", {l_pend, l_req}, {3'b001, 1'b0});
        lstep(3'b001, 0, 3'b000, 0, 0);
        chk("lvl_req", {l_req, l_id, l_vec}, {1'b1, 2'd0, 16'h0004});
        lstep(3'b001, 0, 3'b000, 1, 0);
        chk("lvl_ack_keeps_pend", {l_pend, l_req, l_svc}, {3'b001, 1'b0, 1'b1});
        lstep(3'b001, 0, 3'b000, 0, 1);
        chk("lvl_eoi", {l_req, l_svc}, {1'b0, 1'b0});
        lstep(3'b001, 0, 3'b000, 0, 0);
        chk("lvl_rereq", {l_req, l_id}, {1'b1, 2'd0});
        lstep(3'b000, 0, 3'b000, 0, 0);
        lstep(3'b000, 0, 3'b000, 0, 0);
        lstep(3'b000, 0, 3'b000, 0, 0);
        chk("lvl_drop_pend", {l_pend, l_req}, {3'b000, 1'b1});
        lstep(3'b000, 0, 3'b000, 0, 0);
        chk("lvl_withdraw", {l_req, l_svc}, {1'b0, 1'b0});

        // Randomized traffic on both instances against the model.
        @(negedge clk);
        rst_n = 1'b0;
        {m_irq, m_we, m_sel, m_wd, m_ack, m_eoi} = '0;
        {l_irq, l_we, l_sel, l_wd, l_ack, l_eoi} = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mm = zero_m;
        lm = zero_m;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) m_irq = 3'($urandom);
            if ($urandom_range(0, 3) == 0) l_irq = 3'($urandom);
            m_we = ($urandom_range(0, 7) == 0); m_sel = 1'($urandom); m_wd = 3'($urandom);
            l_we = ($urandom_range(0, 7) == 0); l_sel = 1'($urandom); l_wd = 3'($urandom);
            m_ack = ($urandom_range(0, 2) == 0); m_eoi = ($urandom_range(0, 3) == 0);
            l_ack = ($urandom_range(0, 2) == 0); l_eoi = ($urandom_range(0, 3) == 0);
            mm = mstep(mm, 3'b111, m_irq, m_we, m_sel, m_wd, m_ack, m_eoi);
            lm = mstep(lm, 3'b110, l_irq, l_we, l_sel, l_wd, l_ack, l_eoi);
            cyc();
            chk($sformatf("rand_main_c%0d", c),
                {38'd0, m_mask, m_pend, m_req, m_id, m_vec, m_svc}, mexp(mm));
            chk($sformatf("rand_lvl_c%0d", c),
                {38'd0, l_mask, l_pend, l_req, l_id, l_vec, l_svc}, mexp(lm));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/intc_prio.md
Name: intc_prio

Overview:
Parametrised prioritised interrupt controller sitting between external interrupt lines and the CPU core. It is the next-generation replacement for the CPU's fixed 3-line interrupt input, generalised to N channels with per-channel edge/level mode, masking, a req/ack/EOI handshake and computed vector addresses. It also provides a small config write port driven from the CPU's I/O decode.

Parameters:
N_IRQ, 3, number of interrupt channels (1..16); channel 0 has highest priority.
EDGE_MASK, {N_IRQ{1'b1}}, per-channel mode: 1 = rising-edge latched, 0 = level.
ADDR_W, 16, width of the vector address.
VEC_BASE, 16'h0004, vector address of channel 0.
VEC_STRIDE, 4, address spacing between consecutive channel vectors.
ID_W, 2, channel-ID width; must satisfy 2**ID_W >= N_IRQ.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
irq_in  in  N_IRQ  raw asynchronous interrupt lines
cfg_we  in  1  config write strobe, one cycle
cfg_sel  in  1  0 = write mask register, 1 = write-1-to-clear pending
cfg_wdata  in  N_IRQ  config write data
mask_q  out  N_IRQ  mask register, 1 = channel enabled
pending_q  out  N_IRQ  pending register
int_req  out  1  interrupt request to CPU
int_ack  in  1  CPU accepts request, one cycle
int_id  out  ID_W  ID of the requested or in-service channel
int_vec  out  ADDR_W  vector address of the requested or in-service channel
int_eoi  in  1  end of ISR, one cycle
in_service  out  1  an ISR is active

Behaviour:
- Reset (reset=0, asynchronous): mask_q=0, pending_q=0, sync flops=0, int_req=0, int_id=0, int_vec=0, in_service=0, FSM=IDLE. Reset asserted mid-service aborts everything; no EOI is needed afterwards.
- Synchroniser: per channel, s1<=irq_in, s2<=s1, s3<=s2.
  - Edge channels: pending bit set on the clock edge after s2&~s3.
  - Level channels: pending bit <= s2 every cycle.
  - Latency for both: irq_in sampled high at edge k -> pending_q high after edge k+2.
- Config writes:
  - cfg_we & ~cfg_sel: mask_q <= cfg_wdata.
  - cfg_we & cfg_sel: clears edge pending bits where cfg_wdata=1; level bits are unaffected.
  - An edge set and a clear on the same channel in the same cycle: the set wins.
- Eligible sources = pending_q & mask_q. The winner is the lowest-index eligible bit.
- FSM states IDLE, REQ, SERVICE:
  - IDLE:
    - If any eligible bit is set: go to REQ next edge, latching int_id = winner and int_vec = VEC_BASE + winner*VEC_STRIDE (mod 2**ADDR_W).
    - int_req is registered, so it rises 1 cycle after pending&mask becomes nonzero.
  - REQ (int_req=1):
    - int_id and int_vec are held stable, even if a higher-priority source appears; there is no pre-emption of a posted request.
    - If int_ack=1: go to SERVICE, int_req=0, in_service=1, and clear pending[int_id] if it is an edge channel.
    - Otherwise, if the latched source is no longer eligible (masked, cleared, or level line dropped): go to IDLE, int_req=0 (withdrawn request).
    - int_ack in the same cycle as a withdrawal: ack wins.
  - SERVICE:
    - No nesting; new requests stay pending. int_id and int_vec are held.
    - int_eoi=1: go to IDLE, in_service=0. A still-eligible source re-requests 1 cycle later.
- Spurious handshakes: int_ack outside REQ and int_eoi outside SERVICE are ignored.
- Edge events that arrive while the same channel is in service re-latch pending. A single pending bit is kept per channel; there is no count.

Test Plan:
- Reset, mask=3'b111, pulse irq_in[1] high for 1 cycle -> pending_q=3'b010 at +2 edges, int_req=1 one edge later, int_id=1, int_vec=16'h0008; ack -> pending_q=0, in_service=1; EOI -> IDLE, int_req stays 0.
- irq_in[2] and irq_in[0] rise in the same cycle -> int_id=0, int_vec=16'h0004 first; after ack and EOI, int_id=2, int_vec=16'h000C.
- EDGE_MASK=3'b110, hold irq_in[0] high through ack and EOI -> re-request of id 0 one cycle after EOI; drop irq_in[0] while in REQ -> int_req falls with no ack.
- mask=0, pulse irq_in[1] -> pending_q[1]=1, int_req=0; write mask=3'b010 -> int_req=1 one cycle later; cfg clear with wdata=3'b010 before ack -> request withdrawn to IDLE.
- In SERVICE for id 2, pulse irq_in[0] -> int_req stays 0 until EOI, then id 0 is requested; assert reset mid-SERVICE -> all outputs 0 immediately, without waiting for a clock edge.
- int_ack and int_eoi pulsed in IDLE -> no state change; cfg set and clear on channel 1 in the same cycle -> pending_q[1]=1.
